pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture_if.sv | 33 +++
 rtl/pwm_capture.sv | 135 +++++++++++++
 tb/tb_pwm_capture.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// PWM capture bus: PWM input and enable toward the capture block,
// measured period/high time and status pulses back from it.
interface pwm_capture_if #(
    parameter int COUNTER_WIDTH = 8
);
    logic                     pwm_i;
    logic                     en_i;
    logic [COUNTER_WIDTH-1:0] period_o;
    logic [COUNTER_WIDTH-1:0] high_o;
    logic                     valid_o;
    logic                     timeout_o;
    logic                     level_o;

    modport master (
        output pwm_i,
        output en_i,
        input  period_o,
        input  high_o,
        input  valid_o,
        input  timeout_o,
        input  level_o
    );

    modport slave (
        input  pwm_i,
        input  en_i,
        output period_o,
        output high_o,
        output valid_o,
        output timeout_o,
        output level_o
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with input synchronizer,
// saturation timeout and one-cycle report pulses.
module pwm_capture #(
    parameter int COUNTER_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    pwm_capture_if.slave bus
);
    localparam int W = COUNTER_WIDTH;
    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEASURE
    } state_t;

    state_t state, state_nx;

    logic s1, s, p;
    logic rise, fall;

    logic [W-1:0] pcnt, pcnt_nx;
    logic [W-1:0] hcnt, hcnt_nx;
    logic [W-1:0] period_q, period_nx;
    logic [W-1:0] high_q, high_nx;
    logic hdone, hdone_nx;
    logic upd, upd_nx;
    logic tout, tout_nx;
    logic valid_q;

    assign rise = s & ~p;
    assign fall = ~s & p;

    // two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s  <= 1'b0;
            p  <= 1'b0;
        end else begin
            s1 <= bus.pwm_i;
            s  <= s1;
            p  <= s;
        end
    end

    // state, counters, result registers and output pulse stages
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            hcnt     <= '0;
            hdone    <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            upd      <= 1'b0;
            tout     <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_nx;
            pcnt     <= pcnt_nx;
            hcnt     <= hcnt_nx;
            hdone    <= hdone_nx;
            period_q <= period_nx;
            high_q   <= high_nx;
            upd      <= upd_nx;
            tout     <= tout_nx;
            valid_q  <= upd;
        end
    end

    // next-state and counter update; a rise beats saturation
    always_comb begin
        state_nx  = state;
        pcnt_nx   = pcnt;
        hcnt_nx   = hcnt;
        hdone_nx  = hdone;
        period_nx = period_q;
        high_nx   = high_q;
        upd_nx    = 1'b0;
        tout_nx   = 1'b0;
        if (!bus.en_i) begin
            state_nx = IDLE;
            pcnt_nx  = '0;
            hcnt_nx  = '0;
            hdone_nx = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx = WAIT_RISE;
                    pcnt_nx  = '0;
                    hcnt_nx  = '0;
                    hdone_nx = 1'b0;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_nx = MEASURE;
                        pcnt_nx  = ONE;
                        hcnt_nx  = ONE;
                        hdone_nx = 1'b0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_nx = pcnt;
                        high_nx   = hcnt;
                        upd_nx    = 1'b1;
                        pcnt_nx   = ONE;
                        hcnt_nx   = ONE;
                        hdone_nx  = 1'b0;
                    end else if (pcnt == MAX) begin
                        tout_nx  = 1'b1;
                        state_nx = WAIT_RISE;
                    end else begin
                        pcnt_nx = pcnt + ONE;
                        if (s && !hdone)
                            hcnt_nx = hcnt + ONE;
                        if (fall)
                            hdone_nx = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.period_o  = period_q;
    assign bus.high_o    = high_q;
    assign bus.valid_o   = valid_q;
    assign bus.timeout_o = tout;
    assign bus.level_o   = s;
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: waveforms built from (high, low) period
// lists; reports and timeouts predicted from those durations.
module tb_pwm_capture;
    localparam int W = 8;
    localparam int PMAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;

    pwm_capture_if #(.COUNTER_WIDTH(W)) bus ();

    pwm_capture #(.COUNTER_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
        int idx;
    } rep_t;

    rep_t exp_v[$];
    rep_t obs_v[$];
    int   exp_t[$];
    int   obs_t[$];
    int   hs[$];
    int   ls[$];
    int   cyc = 0;
    int   vectors = 0;
    int   errs = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // one clk cycle: sample outputs at negedge, then drive pwm
    task automatic step(input logic v);
        @(negedge clk);
        if (bus.valid_o)
            obs_v.push_back(rep_t'{int'(bus.period_o),
                                   int'(bus.high_o), cyc});
        if (bus.timeout_o)
            obs_t.push_back(cyc);
        if (bus.valid_o || bus.timeout_o)
            chk("exclusive", int'(bus.valid_o & bus.timeout_o), 0);
        bus.pwm_i = v;
        cyc++;
    endtask

    // Reference: rise driven at index r, period P = h + l.
    // P <= max: report (P, h) seen 4 samples after the next rise.
    // P > max: one timeout seen 258 samples after the rise.
    task automatic play();
        int r;
        int pp;
        for (int i = 0; i < hs.size(); i++) begin
            r  = cyc;
            pp = hs[i] + ls[i];
            if (pp <= PMAX)
                exp_v.push_back(rep_t'{pp, hs[i], r + pp + 4});
            else
                exp_t.push_back(r + 258);
            repeat (hs[i]) step(1'b1);
            repeat (ls[i]) step(1'b0);
        end
        step(1'b1);
        repeat (6) step(1'b0);
        hs.delete();
        ls.delete();
    endtask

    task automatic check_events(input string tag);
        int n;
        chk({tag, " valid count"}, obs_v.size(), exp_v.size());
        chk({tag, " timeout count"}, obs_t.size(), exp_t.size());
        n = (obs_v.size() < exp_v.size()) ? obs_v.size() : exp_v.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, " period"}, obs_v[i].p, exp_v[i].p);
            chk({tag, " high"}, obs_v[i].h, exp_v[i].h);
            chk({tag, " valid time"}, obs_v[i].idx, exp_v[i].idx);
        end
        n = (obs_t.size() < exp_t.size()) ? obs_t.size() : exp_t.size();
        for (int i = 0; i < n; i++)
            chk({tag, " timeout time"}, obs_t[i], exp_t[i]);
        exp_v.delete();
        obs_v.delete();
        exp_t.delete();
        obs_t.delete();
    endtask

    task automatic begin_scn();
        bus.en_i = 1'b1;
        repeat (3) step(1'b0);
    endtask

    task automatic end_scn(input string tag);
        bus.en_i = 1'b0;
        repeat (5) step(1'b0);
        check_events(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " period_o"}, int'(bus.period_o), 0);
        chk({tag, " high_o"}, int'(bus.high_o), 0);
        chk({tag, " valid_o"}, int'(bus.valid_o), 0);
        chk({tag, " timeout_o"}, int'(bus.timeout_o), 0);
        chk({tag, " level_o"}, int'(bus.level_o), 0);
    endtask

    initial begin
        int r;
        int n;
        rst       = 1'b1;
        bus.pwm_i = 1'b1;
        bus.en_i  = 1'b1;
        repeat (3) step(1'b1);
        chk_zero("reset");
        rst      = 1'b0;
        bus.en_i = 1'b0;
        repeat (4) step(1'b0);

        begin_scn();
        hs = '{3, 3, 3, 3};
        ls = '{7, 7, 7, 7};
        play();
        end_scn("p10h3");

        begin_scn();
        hs = '{1, 1, 1, 1, 1};
        ls = '{1, 1, 1, 1, 1};
        play();
        end_scn("p2h1");

        begin_scn();
        hs = '{100, 100, 100, 5};
        ls = '{155, 156, 155, 5};
        play();
        end_scn("p255_p256");

        begin_scn();
        r = cyc;
        exp_v.push_back(rep_t'{10, 4, r + 14});
        repeat (4) step(1'b1);
        repeat (6) step(1'b0);
        r = cyc;
        exp_t.push_back(r + 258);
        repeat (270) step(1'b1);
        chk("stuck level_o", int'(bus.level_o), 1);
        chk("stuck period_o", int'(bus.period_o), 10);
        chk("stuck high_o", int'(bus.high_o), 4);
        repeat (300) step(1'b1);
        repeat (3) step(1'b0);
        end_scn("stuck_high");

        begin_scn();
        hs = '{3, 3};
        ls = '{7, 7};
        play();
        repeat (2) step(1'b0);
        rst = 1'b1;
        step(1'b0);
        chk_zero("mid reset");
        rst = 1'b0;
        check_events("pre_reset");
        repeat (3) step(1'b0);
        hs = '{4, 5};
        ls = '{6, 250};
        play();
        end_scn("post_reset");

        for (int k = 0; k < 6; k++) begin
            begin_scn();
            n = $urandom_range(2, 6);
            for (int i = 0; i < n; i++) begin
                hs.push_back($urandom_range(1, 20));
                if ($urandom_range(0, 3) == 0)
                    ls.push_back($urandom_range(230, 260));
                else
                    ls.push_back($urandom_range(1, 20));
            end
            play();
            end_scn("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end
endmodule
